// File: rtl/echo_repeat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : echo_repeat_fifo
// Description : DEPTH-entry request FIFO. Each request carries a payload and
//               a repeat count, and is replayed on the indication port once
//               per repetition with a sequence index.
//               Optional statistics counters: ECHO_REPEAT_FIFO_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_repeat_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       say__ENA,
  input  logic [DATA_WIDTH-1:0]      say_v,
  input  logic [CNT_WIDTH-1:0]       say_n,
  output logic                       say__RDY,
  input  logic                       respond_rule__ENA,
  output logic                       respond_rule__RDY,
  output logic                       ind_heard__ENA,
  output logic [DATA_WIDTH-1:0]      ind_heard_heard_v,
  output logic [CNT_WIDTH-1:0]       ind_heard_heard_seq,
  input  logic                       ind_heard__RDY,
  output logic [$clog2(DEPTH):0]     occupancy
`ifdef ECHO_REPEAT_FIFO_STATS_EN
  ,
  output logic [31:0]                stat_said,
  output logic [31:0]                stat_heard,
  output logic [31:0]                stat_full_stall
`endif
);

  localparam int                     ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]        OCC_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]        OCC_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]      PTR_ONE  = ADDR_W'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]         occ_q, occ_d;
  logic [CNT_WIDTH-1:0]    rep_q, rep_d;

  logic [DATA_WIDTH-1:0]   mem_v_q [DEPTH];
  logic [CNT_WIDTH-1:0]    mem_n_q [DEPTH];

  logic                    enq;
  logic                    fire;
  logic                    pop;
  logic                    head_last;
  logic [CNT_WIDTH-1:0]    n_eff;
  logic [DATA_WIDTH-1:0]   head_v;
  logic [CNT_WIDTH-1:0]    head_n;

  // Handshake decode: no bypass in either direction, so status depends on
  // registered occupancy only.
  always_comb begin
    say__RDY          = (occ_q != OCC_FULL);
    respond_rule__RDY = (state_q == ST_EMIT) & ind_heard__RDY;
    enq               = say__ENA & say__RDY;
    fire              = respond_rule__ENA & respond_rule__RDY;
    n_eff             = (say_n == '0) ? CNT_ONE : say_n;
    head_v            = mem_v_q[rd_ptr_q];
    head_n            = mem_n_q[rd_ptr_q];
    head_last         = (rep_q == (head_n - CNT_ONE));
    pop               = fire & head_last;
  end

  // Indication outputs are driven straight from the head entry.
  always_comb begin
    ind_heard__ENA      = fire;
    ind_heard_heard_v   = head_v;
    ind_heard_heard_seq = rep_q;
    occupancy           = occ_q;
  end

  // Respond FSM: walks the repetition index of the head entry and pops it
  // after the last beat. Without a fire everything holds.
  always_comb begin
    state_d  = state_q;
    rep_d    = rep_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      ST_IDLE: begin
        rep_d = '0;
        if (enq) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (fire) begin
          if (head_last) begin
            rep_d    = '0;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if ((occ_q == OCC_ONE) && !enq) begin
              state_d = ST_IDLE;
            end
          end else begin
            rep_d = rep_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        rep_d   = '0;
      end
    endcase
  end

  // Write pointer and occupancy bookkeeping; a simultaneous enq and pop
  // leaves occupancy unchanged.
  always_comb begin
    wr_ptr_d = enq ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    case ({enq, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // Control state register; reset discards all stored entries.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      rep_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      rep_q    <= rep_d;
    end
  end

  // Storage array write; contents are qualified by occupancy so no reset.
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem_v_q[wr_ptr_q] <= say_v;
      mem_n_q[wr_ptr_q] <= n_eff;
    end
  end

`ifdef ECHO_REPEAT_FIFO_STATS_EN
  logic [31:0] stat_said_q, stat_said_d;
  logic [31:0] stat_heard_q, stat_heard_d;
  logic [31:0] stat_full_stall_q, stat_full_stall_d;

  // Free-running event counters, wrapping naturally at 2^32.
  always_comb begin
    stat_said_d       = stat_said_q + 32'(enq);
    stat_heard_d      = stat_heard_q + 32'(fire);
    stat_full_stall_d = stat_full_stall_q + 32'(say__ENA & ~say__RDY);
    stat_said         = stat_said_q;
    stat_heard        = stat_heard_q;
    stat_full_stall   = stat_full_stall_q;
  end

  // Statistics registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_said_q       <= '0;
      stat_heard_q      <= '0;
      stat_full_stall_q <= '0;
    end else begin
      stat_said_q       <= stat_said_d;
      stat_heard_q      <= stat_heard_d;
      stat_full_stall_q <= stat_full_stall_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_echo_repeat_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_echo_repeat_fifo
// Description : Self-checking bench for echo_repeat_fifo (vector table plus
//               hand-written multi-cycle sequences, beat scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_repeat_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          say_ena;
  logic [DW-1:0] say_v;
  logic [CW-1:0] say_n;
  logic          say_rdy;
  logic          rsp_ena;
  logic          rsp_rdy;
  logic          heard_ena;
  logic [DW-1:0] heard_v;
  logic [CW-1:0] heard_seq;
  logic          heard_rdy;
  logic [OW-1:0] occupancy;
`ifdef ECHO_REPEAT_FIFO_STATS_EN
  logic [31:0]   stat_said;
  logic [31:0]   stat_heard;
  logic [31:0]   stat_full_stall;
`endif

  echo_repeat_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .CLK                 (clk),
    .nRST                (rst_n),
    .say__ENA            (say_ena),
    .say_v               (say_v),
    .say_n               (say_n),
    .say__RDY            (say_rdy),
    .respond_rule__ENA   (rsp_ena),
    .respond_rule__RDY   (rsp_rdy),
    .ind_heard__ENA      (heard_ena),
    .ind_heard_heard_v   (heard_v),
    .ind_heard_heard_seq (heard_seq),
    .ind_heard__RDY      (heard_rdy),
    .occupancy           (occupancy)
`ifdef ECHO_REPEAT_FIFO_STATS_EN
    ,
    .stat_said           (stat_said),
    .stat_heard          (stat_heard),
    .stat_full_stall     (stat_full_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] v;
    logic [CW-1:0] seq;
    logic          last;
  } beat_t;

  typedef struct {
    int se; int v; int n; int re; int ir;
    int exp_say_rdy; int exp_rsp_rdy; int exp_ena; int exp_occ;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[7];
  int    n_cmp = 0;
  int    n_err = 0;
  int    model_occ = 0;
  int    exp_said = 0;
  int    exp_heard = 0;
  int    exp_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check against the transaction model, and
  // advance the model as if the coming clock edge happens.
  task automatic drive_check(input int se, input int v, input int n, input int re, input int ir);
    logic  fire_exp;
    logic  enq_exp;
    logic  pop_exp;
    int    neff;
    beat_t b;
    say_ena   = (se != 0);
    say_v     = DW'(v);
    say_n     = CW'(n);
    rsp_ena   = (re != 0);
    heard_rdy = (ir != 0);
    #1;
    fire_exp = (re != 0) && (ir != 0) && (model_occ != 0);
    enq_exp  = (se != 0) && (model_occ != DEPTH);
    pop_exp  = 1'b0;
    check("say_rdy", 64'(say_rdy), 64'(model_occ != DEPTH));
    check("rsp_rdy", 64'(rsp_rdy), 64'((model_occ != 0) && (ir != 0)));
    check("heard_ena", 64'(heard_ena), 64'(fire_exp));
    check("occupancy", 64'(occupancy), 64'(model_occ));
    if (fire_exp && sb.size() > 0) begin
      b = sb.pop_front();
      check("heard_v", 64'(heard_v), 64'(b.v));
      check("heard_seq", 64'(heard_seq), 64'(b.seq));
      pop_exp = b.last;
      exp_heard++;
    end
    if (enq_exp) begin
      neff = (n == 0) ? 1 : n;
      for (int k = 0; k < neff; k++) begin
        b.v    = DW'(v);
        b.seq  = CW'(k);
        b.last = (k == neff - 1);
        sb.push_back(b);
      end
      exp_said++;
    end
    if ((se != 0) && !enq_exp) exp_stall++;
    model_occ = model_occ + int'(enq_exp) - int'(pop_exp);
  endtask

  task automatic step(input int se, input int v, input int n, input int re, input int ir);
    drive_check(se, v, n, re, ir);
    @(negedge clk);
  endtask

  task automatic check_stats();
`ifdef ECHO_REPEAT_FIFO_STATS_EN
    check("stat_said", 64'(stat_said), 64'(exp_said));
    check("stat_heard", 64'(stat_heard), 64'(exp_heard));
    check("stat_full_stall", 64'(stat_full_stall), 64'(exp_stall));
`endif
  endtask

  initial begin
    // Basic n=3 request followed by a zero-count request.
    vecs[0] = '{1, 32'h1234, 3, 1, 1, 1, 0, 0, 0};
    vecs[1] = '{0, 0,        0, 1, 1, 1, 1, 1, 1};
    vecs[2] = '{0, 0,        0, 1, 1, 1, 1, 1, 1};
    vecs[3] = '{0, 0,        0, 1, 1, 1, 1, 1, 1};
    vecs[4] = '{1, 32'hAA,   0, 1, 1, 1, 0, 0, 0};
    vecs[5] = '{0, 0,        0, 1, 1, 1, 1, 1, 1};
    vecs[6] = '{0, 0,        0, 1, 1, 1, 0, 0, 0};

    rst_n     = 1'b0;
    say_ena   = 1'b0;
    say_v     = '0;
    say_n     = '0;
    rsp_ena   = 1'b1;
    heard_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_say_rdy", 64'(say_rdy), 64'(1));
    check("rst_rsp_rdy", 64'(rsp_rdy), 64'(0));
    check("rst_heard_ena", 64'(heard_ena), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check_stats();
    rst_n = 1'b1;

    // Table-driven basic and zero-count sequences.
    for (int i = 0; i < 7; i++) begin
      drive_check(vecs[i].se, vecs[i].v, vecs[i].n, vecs[i].re, vecs[i].ir);
      check($sformatf("tbl%0d_say_rdy", i), 64'(say_rdy), 64'(vecs[i].exp_say_rdy));
      check($sformatf("tbl%0d_rsp_rdy", i), 64'(rsp_rdy), 64'(vecs[i].exp_rsp_rdy));
      check($sformatf("tbl%0d_heard_ena", i), 64'(heard_ena), 64'(vecs[i].exp_ena));
      check($sformatf("tbl%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].exp_occ));
      @(negedge clk);
    end

    // Fill under backpressure, overflow attempt, then drain in order.
    for (int i = 1; i <= DEPTH; i++) step(1, i, 1, 1, 0);
    drive_check(1, 5, 1, 1, 0);
    check("full_say_rdy", 64'(say_rdy), 64'(0));
    check("full_occupancy", 64'(occupancy), 64'(DEPTH));
    @(negedge clk);
    check_stats();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // Stall in the middle of a repetition.
    step(1, 7, 4, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // Maximum repeat count: exactly 15 beats, no wrap of the index.
    step(1, 32'h55, 15, 1, 1);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // Streaming with concurrent enq/pop; pointers wrap past DEPTH.
    for (int i = 0; i < 10; i++) begin
      drive_check(1, i, 1, 1, 1);
      if (i > 0) check($sformatf("stream%0d_occupancy", i), 64'(occupancy), 64'(1));
      @(negedge clk);
    end
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    check_stats();

    // Asynchronous reset in the middle of a repetition.
    step(1, 9, 5, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    drive_check(0, 0, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_say_rdy", 64'(say_rdy), 64'(1));
    check("arst_rsp_rdy", 64'(rsp_rdy), 64'(0));
    check("arst_heard_ena", 64'(heard_ena), 64'(0));
    check("arst_occupancy", 64'(occupancy), 64'(0));
    sb.delete();
    model_occ = 0;
    exp_said  = 0;
    exp_heard = 0;
    exp_stall = 0;
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
